text_writer: RTL and testbench
==============================

Name: text_writer

Overview:
- Command-driven producer for the video memory's external write port (write / xtextwrite / ytextwrite / value).
- Accepts character, newline, goto and clear commands over a valid/ready handshake.
- Maintains a text cursor and issues single-cycle cell writes.
- Clear-screen runs as a multi-cycle fill FSM.
- Sits between the host/UART command decoder and video memory, in the same clk domain.

Parameters:
- COLS, `TEXTCOLS_CHAR, text columns
- ROWS, `TEXTROWS_CHAR, text rows

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on clk edge when cmd_valid && cmd_ready
- cmd_op  in  2  0=PUT, 1=NEWLINE, 2=CLEAR, 3=GOTO
- cmd_data  in  `CHARATTR_RANGE  cell value for PUT; fill value for CLEAR
- cmd_x  in  `TEXTCOLS_RANGE  GOTO column
- cmd_y  in  `TEXTROWS_RANGE  GOTO row
- write  out  1  write strobe to video memory
- xtextwrite  out  `TEXTCOLS_RANGE  write column
- ytextwrite  out  `TEXTROWS_RANGE  write row
- value  out  `CHARATTR_RANGE  write data
- busy  out  1  clear fill in progress

Behaviour:
- Reset (async, active-high):
  - state=IDLE; cursor (0,0).
  - write=0, xtextwrite=0, ytextwrite=0, value=0, busy=0.
  - cmd_ready=0 while reset is asserted; cmd_ready=1 from the first edge after release.
- All outputs are registered. cmd_ready = (state==IDLE) && !reset.
- States: IDLE, FILL.
- IDLE, PUT accepted at edge N:
  - Registers write=1, x/y = cursor, value = cmd_data. The strobe is visible during cycle N+1 for exactly one cycle.
  - Cursor advances: x+1.
  - At x==COLS-1: x=0, y+1.
  - At (COLS-1, ROWS-1): wraps to (0,0).
- NEWLINE: x=0; y+1, wrapping ROWS-1 -> 0. No write.
- GOTO:
  - cursor = (cmd_x, cmd_y).
  - Values >= COLS clamp to COLS-1; values >= ROWS clamp to ROWS-1.
  - No write.
- CLEAR accepted at edge N:
  - Latch cmd_data as fill value; enter FILL; busy=1; cmd_ready=0.
  - Each FILL cycle issues write=1 at fill counter (fx,fy), row-major from (0,0).
  - After (COLS-1, ROWS-1) is written: state=IDLE, busy=0, cursor=(0,0).
  - Exactly COLS*ROWS consecutive write cycles, in cycles N+1 .. N+COLS*ROWS. cmd_ready returns high the cycle after the last write.
- write is 0 in every cycle not listed above. Back-to-back PUTs yield a write every cycle.
- cmd_op is ignored when cmd_valid=0. A held cmd_valid with cmd_ready=0 is not consumed.
- Reset mid-FILL: fill aborts immediately and all outputs take their reset values. A partially cleared screen is acceptable.
- Width rules:
  - Address arithmetic in column/row field widths; no linear address is formed here (video memory computes it).
  - Compares use COLS-1 / ROWS-1 sized to the field widths.

Optional Feature:
- Macro TEXT_WRITER_LINEWRAP_EN.
- Defined: PUT wrap as described above.
- Undefined:
  - PUT at x==COLS-1 writes the cell and leaves the cursor at COLS-1. Subsequent PUTs overwrite the last column until NEWLINE or GOTO.
  - Row never auto-advances from PUT.
  - NEWLINE/CLEAR/GOTO unchanged.

Decomposition:
- Shared constant.vh gains the opcode constants (`WOP_PUT, `WOP_NEWLINE, `WOP_CLEAR, `WOP_GOTO) and `WOP_RANGE [1:0].
- Reuse existing `TEXTCOLS_RANGE, `TEXTROWS_RANGE, `CHARATTR_RANGE, `TEXTCOLS_CHAR, `TEXTROWS_CHAR.
- One natural sub-module: text_cursor_counter, an x/y counter with increment, wrap and load.
  - Instantiated twice: once for the cursor, once for the fill counter.

Test Plan (COLS=80, ROWS=30):
- Reset released, PUT data=0x41 -> one write cycle at (0,0) value=0x41; next PUT writes at (1,0).
- GOTO (79,29) then PUT 0x42:
  - With LINEWRAP_EN: write at (79,29), next PUT at (0,0).
  - Without: next PUT at (79,29).
- GOTO (120,40) then PUT -> write at (79,29) (clamped).
- PUT, NEWLINE, PUT, issued back-to-back with cmd_valid held -> writes at (0,0) and (0,1); no write in the NEWLINE cycle.
- CLEAR fill=0x0020:
  - Exactly 2400 consecutive write cycles covering every (x,y) once, row-major; busy=1 throughout, cmd_ready=0.
  - Then cursor (0,0) and cmd_ready=1.
- Reset asserted at fill cycle 100 (async, mid-cycle):
  - write drops to 0 immediately; busy=0.
  - After release, PUT writes at (0,0).

Source files
------------

// File: rtl/text_writer_pkg.sv
// Shared types and constants for the text writer: screen geometry, field widths,
// command opcodes, FSM states and the cell-write payload.
package text_writer_pkg;

    localparam int unsigned TEXTCOLS_CHAR = 80;
    localparam int unsigned TEXTROWS_CHAR = 30;
    localparam int unsigned COLS_W        = 7;
    localparam int unsigned ROWS_W        = 6;
    localparam int unsigned CHARATTR_W    = 16;
    localparam int unsigned WOP_W         = 2;

    typedef enum logic [WOP_W-1:0] {
        WOP_PUT     = 2'd0,
        WOP_NEWLINE = 2'd1,
        WOP_CLEAR   = 2'd2,
        WOP_GOTO    = 2'd3
    } wop_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } tw_state_e;

    typedef struct packed {
        logic [COLS_W-1:0]     x;
        logic [ROWS_W-1:0]     y;
        logic [CHARATTR_W-1:0] value;
    } cell_write_t;

endpackage

// File: rtl/text_cursor_counter.sv
// Column/row counter with increment, newline, clamped load and optional
// end-of-line wrap. Used for both the text cursor and the clear-fill position.
module text_cursor_counter
    import text_writer_pkg::*;
#(
    parameter int unsigned COLS     = TEXTCOLS_CHAR,
    parameter int unsigned ROWS     = TEXTROWS_CHAR,
    parameter bit          LINEWRAP = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_inc,
    input  logic              i_newline,
    input  logic              i_load,
    input  logic [COLS_W-1:0] i_load_x,
    input  logic [ROWS_W-1:0] i_load_y,
    output logic [COLS_W-1:0] o_x,
    output logic [ROWS_W-1:0] o_y
);

    localparam logic [COLS_W-1:0] X_MAX = COLS_W'(COLS - 1);
    localparam logic [ROWS_W-1:0] Y_MAX = ROWS_W'(ROWS - 1);

    logic [COLS_W-1:0] r_x;
    logic [ROWS_W-1:0] r_y;
    logic [COLS_W-1:0] w_x_nxt;
    logic [ROWS_W-1:0] w_y_nxt;
    logic [ROWS_W-1:0] w_y_adv;

    assign w_y_adv = (r_y == Y_MAX) ? '0 : r_y + ROWS_W'(1);

    // Load wins over newline, newline over increment.
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (i_load) begin
            w_x_nxt = (i_load_x > X_MAX) ? X_MAX : i_load_x;
            w_y_nxt = (i_load_y > Y_MAX) ? Y_MAX : i_load_y;
        end else if (i_newline) begin
            w_x_nxt = '0;
            w_y_nxt = w_y_adv;
        end else if (i_inc) begin
            if (r_x != X_MAX) begin
                w_x_nxt = r_x + COLS_W'(1);
            end else if (LINEWRAP) begin
                w_x_nxt = '0;
                w_y_nxt = w_y_adv;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
        end
    end

    assign o_x = r_x;
    assign o_y = r_y;

endmodule

// File: rtl/text_writer.sv
// Command-driven producer for the video memory write port: PUT / NEWLINE / GOTO /
// CLEAR. Define TEXT_WRITER_LINEWRAP_EN to make PUT wrap to the next line.
module text_writer
    import text_writer_pkg::*;
#(
    parameter int unsigned COLS = TEXTCOLS_CHAR,
    parameter int unsigned ROWS = TEXTROWS_CHAR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [WOP_W-1:0]      cmd_op,
    input  logic [CHARATTR_W-1:0] cmd_data,
    input  logic [COLS_W-1:0]     cmd_x,
    input  logic [ROWS_W-1:0]     cmd_y,
    output logic                  write,
    output logic [COLS_W-1:0]     xtextwrite,
    output logic [ROWS_W-1:0]     ytextwrite,
    output logic [CHARATTR_W-1:0] value,
    output logic                  busy
);

`ifdef TEXT_WRITER_LINEWRAP_EN
    localparam bit CURSOR_WRAP = 1'b1;
`else
    localparam bit CURSOR_WRAP = 1'b0;
`endif

    localparam logic [COLS_W-1:0] X_MAX = COLS_W'(COLS - 1);
    localparam logic [ROWS_W-1:0] Y_MAX = ROWS_W'(ROWS - 1);

    tw_state_e             r_state;
    tw_state_e             w_state_nxt;
    logic                  r_write;
    logic                  w_write_nxt;
    cell_write_t           r_wr;
    cell_write_t           w_wr_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic                  r_cmd_ready;
    logic                  w_ready_nxt;
    logic [CHARATTR_W-1:0] r_fill_val;
    logic [CHARATTR_W-1:0] w_fill_val_nxt;
    logic                  r_fill_last;
    logic                  w_fill_last_nxt;

    logic                  w_accept;
    logic                  w_cur_inc;
    logic                  w_cur_nl;
    logic                  w_cur_load;
    logic [COLS_W-1:0]     w_cur_ld_x;
    logic [ROWS_W-1:0]     w_cur_ld_y;
    logic [COLS_W-1:0]     w_cur_x;
    logic [ROWS_W-1:0]     w_cur_y;
    logic                  w_fill_inc;
    logic [COLS_W-1:0]     w_fill_x;
    logic [ROWS_W-1:0]     w_fill_y;
    logic                  w_fill_last_c;

    text_cursor_counter #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .LINEWRAP (CURSOR_WRAP)
    ) u_cursor (
        .clk       (clk),
        .reset     (reset),
        .i_inc     (w_cur_inc),
        .i_newline (w_cur_nl),
        .i_load    (w_cur_load),
        .i_load_x  (w_cur_ld_x),
        .i_load_y  (w_cur_ld_y),
        .o_x       (w_cur_x),
        .o_y       (w_cur_y)
    );

    // Fill position always wraps, so it rests at (0,0) whenever the FSM is idle.
    text_cursor_counter #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .LINEWRAP (1'b1)
    ) u_fill (
        .clk       (clk),
        .reset     (reset),
        .i_inc     (w_fill_inc),
        .i_newline (1'b0),
        .i_load    (1'b0),
        .i_load_x  ('0),
        .i_load_y  ('0),
        .o_x       (w_fill_x),
        .o_y       (w_fill_y)
    );

    assign w_accept      = cmd_valid && r_cmd_ready;
    assign w_fill_last_c = (w_fill_x == X_MAX) && (w_fill_y == Y_MAX);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_write_nxt     = 1'b0;
        w_wr_nxt        = r_wr;
        w_busy_nxt      = 1'b0;
        w_ready_nxt     = 1'b1;
        w_fill_val_nxt  = r_fill_val;
        w_fill_last_nxt = r_fill_last;
        w_cur_inc       = 1'b0;
        w_cur_nl        = 1'b0;
        w_cur_load      = 1'b0;
        w_cur_ld_x      = '0;
        w_cur_ld_y      = '0;
        w_fill_inc      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    unique case (wop_e'(cmd_op))
                        WOP_PUT: begin
                            w_write_nxt    = 1'b1;
                            w_wr_nxt.x     = w_cur_x;
                            w_wr_nxt.y     = w_cur_y;
                            w_wr_nxt.value = cmd_data;
                            w_cur_inc      = 1'b1;
                        end
                        WOP_NEWLINE: begin
                            w_cur_nl = 1'b1;
                        end
                        WOP_GOTO: begin
                            w_cur_load = 1'b1;
                            w_cur_ld_x = cmd_x;
                            w_cur_ld_y = cmd_y;
                        end
                        WOP_CLEAR: begin
                            // First fill cell is written in the cycle right after acceptance.
                            w_state_nxt     = ST_FILL;
                            w_write_nxt     = 1'b1;
                            w_wr_nxt.x      = w_fill_x;
                            w_wr_nxt.y      = w_fill_y;
                            w_wr_nxt.value  = cmd_data;
                            w_fill_val_nxt  = cmd_data;
                            w_fill_inc      = 1'b1;
                            w_fill_last_nxt = w_fill_last_c;
                            w_busy_nxt      = 1'b1;
                            w_ready_nxt     = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_FILL: begin
                if (r_fill_last) begin
                    w_state_nxt     = ST_IDLE;
                    w_fill_last_nxt = 1'b0;
                    w_cur_load      = 1'b1;
                end else begin
                    w_write_nxt     = 1'b1;
                    w_wr_nxt.x      = w_fill_x;
                    w_wr_nxt.y      = w_fill_y;
                    w_wr_nxt.value  = r_fill_val;
                    w_fill_inc      = 1'b1;
                    w_fill_last_nxt = w_fill_last_c;
                    w_busy_nxt      = 1'b1;
                    w_ready_nxt     = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_wr        <= '0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_fill_val  <= '0;
            r_fill_last <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_write     <= w_write_nxt;
            r_wr        <= w_wr_nxt;
            r_busy      <= w_busy_nxt;
            r_cmd_ready <= w_ready_nxt;
            r_fill_val  <= w_fill_val_nxt;
            r_fill_last <= w_fill_last_nxt;
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign write      = r_write;
    assign xtextwrite = r_wr.x;
    assign ytextwrite = r_wr.y;
    assign value      = r_wr.value;
    assign busy       = r_busy;

endmodule

// File: tb/tb_text_writer.sv
// Self-checking bench for text_writer: directed vector table, clear-fill and
// mid-fill reset sequences, and random commands against a screen-level model.
module tb_text_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int NCELL = COLS * ROWS;

`ifdef TEXT_WRITER_LINEWRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [6:0]  cmd_x;
    logic [5:0]  cmd_y;
    logic        write;
    logic [6:0]  xtextwrite;
    logic [5:0]  ytextwrite;
    logic [15:0] value;
    logic        busy;

    text_writer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .write      (write),
        .xtextwrite (xtextwrite),
        .ytextwrite (ytextwrite),
        .value      (value),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Screen-level model: cursor, fill progress, expected outputs for the current cycle.
    int          m_cx, m_cy, m_fidx;
    bit          m_filling, m_ready;
    logic [15:0] m_fval;
    bit          e_write;
    int          e_x, e_y;
    logic [15:0] e_val;

    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic [15:0] d;
        logic [6:0]  x;
        logic [5:0]  y;
        logic        ew;
        int          ex;
        int          ey;
        logic [15:0] ev;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cx = 0; m_cy = 0; m_fidx = 0;
        m_filling = 1'b0; m_ready = 1'b0;
        m_fval = '0; e_write = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [1:0] op, input logic [15:0] d,
                              input int x, input int y);
        int lin;
        e_write = 1'b0;
        if (!m_filling && v && m_ready) begin
            case (op)
                2'd0: begin
                    e_write = 1'b1; e_x = m_cx; e_y = m_cy; e_val = d;
                    if (WRAP) begin
                        lin  = (m_cy * COLS + m_cx + 1) % NCELL;
                        m_cx = lin % COLS;
                        m_cy = lin / COLS;
                    end else if (m_cx < COLS - 1) begin
                        m_cx = m_cx + 1;
                    end
                end
                2'd1: begin
                    m_cx = 0;
                    m_cy = (m_cy + 1) % ROWS;
                end
                2'd2: begin
                    m_filling = 1'b1; m_fidx = 0; m_fval = d;
                end
                default: begin
                    m_cx = (x >= COLS) ? COLS - 1 : x;
                    m_cy = (y >= ROWS) ? ROWS - 1 : y;
                end
            endcase
        end
        if (m_filling) begin
            if (m_fidx < NCELL) begin
                e_write = 1'b1;
                e_x = m_fidx % COLS; e_y = m_fidx / COLS; e_val = m_fval;
                m_fidx++;
            end else begin
                m_filling = 1'b0;
                m_cx = 0; m_cy = 0;
            end
        end
        m_ready = !m_filling;
    endtask

    // One clock: drive, let the edge happen, update the model, sample and compare.
    task automatic do_cycle(input logic v, input logic [1:0] op, input logic [15:0] d,
                            input logic [6:0] x, input logic [5:0] y);
        cmd_valid = v; cmd_op = op; cmd_data = d; cmd_x = x; cmd_y = y;
        @(posedge clk);
        model_edge(v, op, d, int'(x), int'(y));
        #1;
        chk("write", int'(write), int'(e_write));
        chk("busy", int'(busy), int'(m_filling));
        chk("cmd_ready", int'(cmd_ready), int'(m_ready));
        if (e_write) begin
            chk("xtextwrite", int'(xtextwrite), e_x);
            chk("ytextwrite", int'(ytextwrite), e_y);
            chk("value", int'(value), int'(e_val));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_write"}, int'(write), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_ready"}, int'(cmd_ready), 0);
        chk({tag, "_x"}, int'(xtextwrite), 0);
        chk({tag, "_y"}, int'(ytextwrite), 0);
        chk({tag, "_value"}, int'(value), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        int budget;
        logic [1:0] rop;

        // {valid, op, data, x, y, exp_write, exp_x, exp_y, exp_value}
        tbl[0]  = '{1'b1, 2'd0, 16'h0041, 7'd0,   6'd0,  1'b1, 0,  0,  16'h0041};
        tbl[1]  = '{1'b1, 2'd0, 16'h0043, 7'd0,   6'd0,  1'b1, 1,  0,  16'h0043};
        tbl[2]  = '{1'b1, 2'd3, 16'h0000, 7'd79,  6'd29, 1'b0, 0,  0,  16'h0000};
        tbl[3]  = '{1'b1, 2'd0, 16'h0042, 7'd0,   6'd0,  1'b1, 79, 29, 16'h0042};
        tbl[4]  = '{1'b1, 2'd0, 16'h0044, 7'd0,   6'd0,  1'b1, WRAP ? 0 : 79, WRAP ? 0 : 29, 16'h0044};
        tbl[5]  = '{1'b1, 2'd3, 16'h0000, 7'd120, 6'd40, 1'b0, 0,  0,  16'h0000};
        tbl[6]  = '{1'b1, 2'd0, 16'h0045, 7'd0,   6'd0,  1'b1, 79, 29, 16'h0045};
        tbl[7]  = '{1'b1, 2'd3, 16'h0000, 7'd0,   6'd0,  1'b0, 0,  0,  16'h0000};
        tbl[8]  = '{1'b1, 2'd0, 16'h0046, 7'd0,   6'd0,  1'b1, 0,  0,  16'h0046};
        tbl[9]  = '{1'b1, 2'd1, 16'h0000, 7'd0,   6'd0,  1'b0, 0,  0,  16'h0000};
        tbl[10] = '{1'b1, 2'd0, 16'h0047, 7'd0,   6'd0,  1'b1, 0,  1,  16'h0047};
        tbl[11] = '{1'b0, 2'd0, 16'h0048, 7'd0,   6'd0,  1'b0, 0,  0,  16'h0000};

        // Reset state
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_x = '0; cmd_y = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        do_cycle(1'b0, 2'd0, 16'h0, 7'd0, 6'd0);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            do_cycle(tbl[i].v, tbl[i].op, tbl[i].d, tbl[i].x, tbl[i].y);
            chk($sformatf("tbl%0d_write", i), int'(write), int'(tbl[i].ew));
            if (tbl[i].ew) begin
                chk($sformatf("tbl%0d_x", i), int'(xtextwrite), tbl[i].ex);
                chk($sformatf("tbl%0d_y", i), int'(ytextwrite), tbl[i].ey);
                chk($sformatf("tbl%0d_value", i), int'(value), int'(tbl[i].ev));
            end
        end

        // Clear fill with a PUT held on the command port throughout
        do_cycle(1'b1, 2'd2, 16'h0020, 7'd5, 6'd5);
        idx = 0;
        budget = 0;
        while (cmd_ready !== 1'b1 && budget < NCELL + 10) begin
            chk("fill_write", int'(write), 1);
            chk("fill_order", int'(xtextwrite) + int'(ytextwrite) * COLS, idx);
            chk("fill_value", int'(value), 16'h0020);
            idx++;
            do_cycle(1'b1, 2'd0, 16'h0055, 7'd0, 6'd0);
            budget++;
        end
        chk("fill_count", idx, NCELL);
        chk("fill_done_busy", int'(busy), 0);
        chk("fill_done_write", int'(write), 0);
        do_cycle(1'b1, 2'd0, 16'h0055, 7'd0, 6'd0);
        chk("post_clear_x", int'(xtextwrite), 0);
        chk("post_clear_y", int'(ytextwrite), 0);
        chk("post_clear_write", int'(write), 1);

        // Random commands; CLEAR kept rare so fills stay affordable
        for (int i = 0; i < 400; i++) begin
            rop = 2'($urandom_range(0, 3));
            if (rop == 2'd2 && $urandom_range(0, 49) != 0) rop = 2'd0;
            do_cycle(1'($urandom_range(0, 3) != 0), rop, 16'($urandom()),
                     7'($urandom_range(0, 127)), 6'($urandom_range(0, 63)));
        end
        while (m_filling) do_cycle(1'b0, 2'd0, 16'h0, 7'd0, 6'd0);

        // Reset asserted mid-cycle during fill cycle 100
        do_cycle(1'b1, 2'd2, 16'h0020, 7'd0, 6'd0);
        for (int i = 0; i < 99; i++) do_cycle(1'b0, 2'd0, 16'h0, 7'd0, 6'd0);
        chk("fill100_write", int'(write), 1);
        chk("fill100_pos", int'(xtextwrite) + int'(ytextwrite) * COLS, 99);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midfill_reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midfill_held");
        reset = 1'b0;
        do_cycle(1'b0, 2'd0, 16'h0, 7'd0, 6'd0);
        do_cycle(1'b1, 2'd0, 16'h0061, 7'd9, 6'd9);
        chk("after_reset_put_x", int'(xtextwrite), 0);
        chk("after_reset_put_y", int'(ytextwrite), 0);
        chk("after_reset_put_write", int'(write), 1);
        do_cycle(1'b0, 2'd0, 16'h0, 7'd0, 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
